// File: rtl/alu_response_recorder_if.sv
// Capture and readback bus of the ALU response recorder.
// Handshake: cap_valid qualifies a_in/b_in/control_in/op_in/flags_in in the same cycle
// (no back-pressure). A rd_req is taken when the buffer is non-empty. The data is returned
// on the following cycle with rd_valid high for one cycle.
interface alu_response_recorder_if #(
  parameter int WIDTH  = 8,
  parameter int CTRL_W = 3
);
  localparam int REC_W = 2*WIDTH + CTRL_W + WIDTH + 4;

  logic              cap_valid;
  logic [WIDTH-1:0]  a_in;
  logic [WIDTH-1:0]  b_in;
  logic [CTRL_W-1:0] control_in;
  logic [WIDTH-1:0]  op_in;
  logic [3:0]        flags_in;
  logic              rd_req;
  logic              rd_valid;
  logic [REC_W-1:0]  rd_data;

  modport master (
    output cap_valid, a_in, b_in, control_in, op_in, flags_in, rd_req,
    input  rd_valid, rd_data
  );

  modport slave (
    input  cap_valid, a_in, b_in, control_in, op_in, flags_in, rd_req,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/alu_response_recorder.sv
// Records ALU {a,b,control,op,flags} tuples while ARMED and plays them back in FIFO order.
// Optional ALU_REC_CMP_EN adds expected-result comparison (err_count, first_err_idx).
module alu_response_recorder #(
  parameter int WIDTH  = 8,
  parameter int CTRL_W = 3,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     wrap_mode,
  alu_response_recorder_if.slave   bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic [1:0]               state
`ifdef ALU_REC_CMP_EN
  ,
  input  logic [WIDTH-1:0]         exp_in,
  output logic [7:0]               err_count,
  output logic [$clog2(DEPTH):0]   first_err_idx
`endif
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int REC_W = 2*WIDTH + CTRL_W + WIDTH + 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_d;
  logic              do_cap, do_rd;
  logic [REC_W-1:0]  mem [DEPTH];

  assign state = state_q;
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_comb begin
    do_rd   = bus.rd_req && !empty && !arm;
    // A full buffer in non-wrap mode only accepts a capture if a read frees a slot.
    do_cap  = (state_q == ST_ARMED) && bus.cap_valid && !arm &&
              (!full || wrap_mode || do_rd);
    count_d = count;
    if (do_cap && !do_rd && !full)      count_d = count + CW'(1);
    else if (do_rd && !do_cap)          count_d = count - CW'(1);

    state_d = state_q;
    if (arm) begin
      state_d = ST_ARMED;
    end else if (state_q == ST_ARMED) begin
      if (stop)                                                  state_d = ST_DONE;
      else if (do_cap && !wrap_mode && count_d == CW'(DEPTH))   state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      bus.rd_valid <= do_rd;
      if (do_rd) bus.rd_data <= mem[rd_ptr];
      if (arm) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        count <= count_d;
        if (do_cap) wr_ptr <= wr_ptr + AW'(1);
        // Overwriting the oldest entry drags the read pointer along with it.
        if (do_rd || (do_cap && full)) rd_ptr <= rd_ptr + AW'(1);
        if (do_cap && full && !do_rd)  overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_cap)
      mem[wr_ptr] <= {bus.a_in, bus.b_in, bus.control_in, bus.op_in, bus.flags_in};
  end

`ifdef ALU_REC_CMP_EN
  logic [CW-1:0] cap_ord;
  logic          cmp_err;

  assign cmp_err = do_cap && (bus.op_in != exp_in);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_ord       <= '0;
      err_count     <= '0;
      first_err_idx <= '1;
    end else if (arm) begin
      cap_ord       <= '0;
      err_count     <= '0;
      first_err_idx <= '1;
    end else begin
      if (do_cap) cap_ord <= cap_ord + CW'(1);
      if (cmp_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (cmp_err && first_err_idx == '1) first_err_idx <= cap_ord;
    end
  end
`endif
endmodule

// File: tb/tb_alu_response_recorder.sv
// Directed bench for alu_response_recorder: capture/readback, full handling, arm priority, reset.
module tb_alu_response_recorder;
  localparam int WIDTH = 8;
  localparam int CTRL_W = 3;
  localparam int DEPTH = 16;
  localparam int REC_W = 2*WIDTH + CTRL_W + WIDTH + 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic arm = 1'b0, stop = 1'b0, wrap_mode = 1'b0;
  logic [4:0] count;
  logic empty, full, overflow;
  logic [1:0] state;
`ifdef ALU_REC_CMP_EN
  logic [WIDTH-1:0] exp_in = '0;
  logic [7:0] err_count;
  logic [4:0] first_err_idx;
`endif

  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] last_rec;
  int n_checks = 0;
  int n_errors = 0;

  alu_response_recorder_if #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) bus ();

  alu_response_recorder #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .arm(arm), .stop(stop), .wrap_mode(wrap_mode),
    .bus(bus), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .state(state)
`ifdef ALU_REC_CMP_EN
    , .exp_in(exp_in), .err_count(err_count), .first_err_idx(first_err_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] mk(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] c, input logic [7:0] op,
                                          input logic [3:0] f);
    return {a, b, c, op, f};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tuple(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c,
                           input logic [7:0] op, input logic [3:0] f);
    bus.a_in = a; bus.b_in = b; bus.control_in = c; bus.op_in = op; bus.flags_in = f;
  endtask

  task automatic cap(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c,
                     input logic [7:0] op, input logic [3:0] f);
    set_tuple(a, b, c, op, f);
    bus.cap_valid = 1'b1;
    tick();
    bus.cap_valid = 1'b0;
  endtask

  // Capture a tuple derived from op; the model keeps at most DEPTH entries (wrap model).
  task automatic cap_op(input logic [7:0] op, input bit push);
    cap(op ^ 8'h5A, ~op, op[2:0], op, op[3:0]);
    if (push) begin
      exp_q.push_back(mk(op ^ 8'h5A, ~op, op[2:0], op, op[3:0]));
      if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    exp_q.delete();
  endtask

  task automatic pop_check(input string tag);
    logic [REC_W-1:0] e;
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_valid"}, bus.rd_valid, 1'b1);
    check({tag, "_data"}, bus.rd_data, e);
    last_rec = e;
  endtask

  initial begin
    bus.cap_valid = 1'b0; bus.rd_req = 1'b0;
    set_tuple(8'h00, 8'h00, 3'b000, 8'h00, 4'h0);
    #1;
    check("rst_state", state, 2'b00);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_rdv", bus.rd_valid, 1'b0);
    check("rst_rdd", bus.rd_data, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Basic capture and readback
    do_arm();
    check("arm_state", state, 2'b01);
    cap(8'h05, 8'h03, 3'b010, 8'h08, 4'b0000);
    exp_q.push_back(mk(8'h05, 8'h03, 3'b010, 8'h08, 4'b0000));
    check("cap1_count", count, 1);
    cap(8'h0A, 8'h04, 3'b110, 8'h0E, 4'b0000);
    exp_q.push_back(mk(8'h0A, 8'h04, 3'b110, 8'h0E, 4'b0000));
    cap(8'hFF, 8'h01, 3'b010, 8'h00, 4'b1001);
    exp_q.push_back(mk(8'hFF, 8'h01, 3'b010, 8'h00, 4'b1001));
    check("cap3_count", count, 3);
    pop_check("basic0"); check("basic0_cnt", count, 2);
    pop_check("basic1"); check("basic1_cnt", count, 1);
    pop_check("basic2"); check("basic2_cnt", count, 0);
    check("basic_empty", empty, 1'b1);
    bus.rd_req = 1'b1; tick(); bus.rd_req = 1'b0;
    check("empty_rd_valid", bus.rd_valid, 1'b0);
    check("empty_rd_hold", bus.rd_data, last_rec);
    check("empty_rd_count", count, 0);

    // Non-wrap fill: 16th capture goes to DONE, the rest are dropped
    wrap_mode = 1'b0;
    do_arm();
    for (int i = 0; i < 20; i++) begin
      cap_op(8'(i), i < DEPTH);
      if (i == 14) check("nw_state15", state, 2'b01);
      if (i == 15) begin
        check("nw_state16", state, 2'b10);
        check("nw_full16", full, 1'b1);
      end
    end
    check("nw_count", count, 16);
    check("nw_ovf", overflow, 1'b0);
    for (int i = 0; i < DEPTH; i++) pop_check("nw_rd");
    check("nw_after_count", count, 0);

    // Wrap: simultaneous capture and read at full, then overwrite
    wrap_mode = 1'b1;
    do_arm();
    for (int i = 0; i < DEPTH; i++) cap_op(8'h40 + 8'(i), 1'b1);
    check("w_full", full, 1'b1);
    check("w_ovf0", overflow, 1'b0);
    set_tuple(8'h11, 8'h22, 3'b101, 8'h50, 4'b0110);
    bus.cap_valid = 1'b1; bus.rd_req = 1'b1;
    tick();
    bus.cap_valid = 1'b0; bus.rd_req = 1'b0;
    check("sim_valid", bus.rd_valid, 1'b1);
    check("sim_data", bus.rd_data, exp_q.pop_front());
    exp_q.push_back(mk(8'h11, 8'h22, 3'b101, 8'h50, 4'b0110));
    check("sim_count", count, 16);
    check("sim_ovf", overflow, 1'b0);
    for (int i = 1; i <= 4; i++) cap_op(8'h50 + 8'(i), 1'b1);
    check("w_ovf1", overflow, 1'b1);
    check("w_count", count, 16);
    check("w_state", state, 2'b01);
    for (int i = 0; i < DEPTH; i++) pop_check("w_rd");

    // Wrap: 20 captures of op=0..19 read back as 4..19
    do_arm();
    check("arm_clr_ovf", overflow, 1'b0);
    for (int i = 0; i < 20; i++) cap_op(8'(i), 1'b1);
    check("w20_count", count, 16);
    check("w20_ovf", overflow, 1'b1);
    for (int i = 0; i < DEPTH; i++) pop_check("w20_rd");
    check("w20_empty", empty, 1'b1);

    // arm beats stop and rd_req
    wrap_mode = 1'b0;
    do_arm();
    for (int i = 0; i < 5; i++) cap_op(8'h80 + 8'(i), 1'b1);
    check("pri_count5", count, 5);
    arm = 1'b1; stop = 1'b1; bus.rd_req = 1'b1;
    tick();
    arm = 1'b0; stop = 1'b0; bus.rd_req = 1'b0;
    exp_q.delete();
    check("pri_count", count, 0);
    check("pri_state", state, 2'b01);
    check("pri_rdv", bus.rd_valid, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_state", state, 2'b10);

    // Asynchronous reset in the middle of a capture
    do_arm();
    cap_op(8'h33, 1'b1);
    cap_op(8'h34, 1'b1);
    pop_check("prerst");
    set_tuple(8'h77, 8'h66, 3'b001, 8'h55, 4'b1111);
    bus.cap_valid = 1'b1;
    #3 reset = 1'b0;
    #1;
    check("arst_state", state, 2'b00);
    check("arst_count", count, 0);
    check("arst_empty", empty, 1'b1);
    check("arst_rdv", bus.rd_valid, 1'b0);
    check("arst_rdd", bus.rd_data, 0);
    check("arst_ovf", overflow, 1'b0);
    bus.cap_valid = 1'b0;
    #2 reset = 1'b1;
    tick();
    exp_q.delete();
    check("post_rst_state", state, 2'b00);

`ifdef ALU_REC_CMP_EN
    check("cmp_rst_err", err_count, 0);
    check("cmp_rst_idx", first_err_idx, 5'h1F);
    do_arm();
    for (int i = 0; i < 4; i++) begin
      exp_in = i[0] ? 8'h11 : 8'h10;
      cap(8'h01, 8'h02, 3'b000, 8'h10, 4'h0);
    end
    check("cmp_err", err_count, 2);
    check("cmp_idx", first_err_idx, 1);
    do_arm();
    check("cmp_arm_err", err_count, 0);
    check("cmp_arm_idx", first_err_idx, 5'h1F);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_response_recorder.md
Name: alu_response_recorder

Overview:
Synthesizable capture buffer that records ALU stimulus/response tuples {A, B, control, result, flags} into an on-chip memory while armed, and plays them back through a read handshake. It is the write-side counterpart to the file-driven vector reader in the ALU bench. It sits beside the multi-cycle datapath's ALU, snooping its operand, control and result/flag buses. Recorded words can be dumped later in vector format for regression.

Parameters:
WIDTH, 8, ALU operand/result width
CTRL_W, 3, ALU control field width
DEPTH, 16, buffer entries (power of two, >=2)
REC_W, 2*WIDTH+CTRL_W+WIDTH+4, record width (derived, not overridable)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
arm  in  1  pulse: clear buffer and enter ARMED
stop  in  1  pulse: end capture, enter DONE
wrap_mode  in  1  1 = overwrite oldest when full; 0 = stop when full
cap_valid  in  1  ALU tuple on inputs is valid this cycle
a_in  in  WIDTH  ALU operand A
b_in  in  WIDTH  ALU operand B
control_in  in  CTRL_W  ALU control
op_in  in  WIDTH  ALU result
flags_in  in  4  {c,v,n,z}
rd_req  in  1  pop request
rd_valid  out  1  rd_data valid (one-cycle pulse)
rd_data  out  REC_W  {a,b,control,op,c,v,n,z}, MSB first
count  out  $clog2(DEPTH)+1  entries held
empty  out  1  count==0
full  out  1  count==DEPTH
overflow  out  1  sticky: a record was overwritten in wrap mode
state  out  2  00 IDLE, 01 ARMED, 10 DONE

Behaviour:
- Reset (reset=0, async): state=IDLE, pointers=0, count=0, empty=1, full=0, overflow=0, rd_valid=0, rd_data=0. Memory contents need not be cleared.
- IDLE -> ARMED on arm. ARMED -> DONE on stop, or on reaching full with wrap_mode=0. DONE -> ARMED on arm. Any state + arm: pointers, count and overflow cleared next edge; rd_valid forced 0 that cycle. arm has priority over stop and over all same-cycle captures and reads.
- Capture occurs only in ARMED with cap_valid=1. The tuple is written at wr_ptr on the same edge and is visible in count on the next cycle.
- Full with wrap_mode=0: the write that fills the buffer is accepted and the state goes to DONE on that same edge. No further captures are taken.
- Full with wrap_mode=1: the capture overwrites the oldest entry, wr_ptr and rd_ptr both advance, count stays DEPTH, and overflow is set (sticky until arm or reset).
- Read: rd_req=1 with count>0 gives rd_valid=1 with rd_data=mem[rd_ptr] on the next cycle; rd_ptr advances and count decrements. rd_req with empty is ignored (rd_valid=0, rd_data holds its last value). Reads are allowed in every state.
- Simultaneous capture and read, not full: both are performed and count is unchanged.
- Simultaneous capture and read, full with wrap_mode=1: the read returns the oldest entry, the write lands in the freed slot, and overflow is not set.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows.
- rd_data is registered and held between pops.
- Throughput: one capture and one read per cycle.

Optional Feature:
ALU_REC_CMP_EN:
- Defined: adds ports exp_in (in, WIDTH), err_count (out, 8) and first_err_idx (out, $clog2(DEPTH)+1).
- On each accepted capture where op_in !== exp_in, err_count increments, saturating at 255.
- first_err_idx latches the capture ordinal (0-based, since last arm) of the first mismatch. It reads all-ones if there has been none.
- arm and reset clear err_count to 0 and set first_err_idx to all-ones.
- Undefined: these ports and this logic are absent; all other behaviour is identical.

Test Plan:
- Reset then arm, capture 3 tuples (A=0x05, B=0x03, ctrl=010, op=0x08, flags=0000; then 2 more), 3 rd_req -> rd_valid pulses 1 cycle after each req, data in capture order, count 3->0, empty=1.
- wrap_mode=0, DEPTH=16, 20 consecutive captures -> count=16, full=1, state=10 on the 16th edge, captures 17-20 dropped, readback yields entries 0..15.
- wrap_mode=1, 20 captures of op=0..19 -> count=16, overflow=1, readback op=4..19.
- Full with wrap, cap_valid and rd_req in same cycle -> rd_data is the oldest entry, count stays 16, overflow unchanged.
- arm asserted with stop and rd_req while count=5 -> next cycle count=0, state=01, rd_valid=0. Separately, reset deasserted-low mid-capture -> all outputs return to reset values immediately.
- With ALU_REC_CMP_EN: 4 captures, mismatch on ordinals 1 and 3 (op=0x10, exp=0x11) -> err_count=2, first_err_idx=1. Then arm -> err_count=0, first_err_idx=all-ones.
